// File: rtl/wb_serial_tx_pkg.sv
// Shared constants and types for the Wishbone serial transmitter.
// Register offsets, FSM state encoding and the default frame width.
package wb_serial_pkg;

    localparam int WB_W        = 32;
    localparam int DIV_W       = 16;
    localparam int FRAME_W_DEF = 10;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_DIV    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_NONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SHIFT = 2'd2
    } tx_state_e;

    function automatic logic [WB_W-1:0] status_word(
        input logic busy,
        input logic pend
    );
        return {{(WB_W-2){1'b0}}, pend, busy};
    endfunction

endpackage

// File: rtl/wb_serial_tx_if.sv
// Wishbone classic bus bundle between a master and the serial transmitter.
// Signal names keep the slave-side Wishbone naming.
interface wb_serial_if;
    import wb_serial_pkg::*;

    logic            CYC_I;
    logic            STB_I;
    logic            WE_I;
    logic [WB_W-1:0] ADR_I;
    logic [WB_W-1:0] DAT_I;
    logic [WB_W-1:0] DAT_O;
    logic            ACK_O;

    modport slave (
        input  CYC_I,
        input  STB_I,
        input  WE_I,
        input  ADR_I,
        input  DAT_I,
        output DAT_O,
        output ACK_O
    );

    modport master (
        output CYC_I,
        output STB_I,
        output WE_I,
        output ADR_I,
        output DAT_I,
        input  DAT_O,
        input  ACK_O
    );

endinterface

// File: rtl/wb_serial_tx_bit_timer.sv
// Bit-period tick generator: one tick every i_div+1 enabled clocks.
// The period is latched at each restart or tick so a divider change never cuts a bit short.
module bit_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_restart,
    input  logic         i_en,
    input  logic [W-1:0] i_div,
    output logic         o_tick
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_period;

    assign o_tick = i_en & (r_cnt == r_period);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_period <= '0;
        end else if (i_restart) begin
            r_cnt    <= '0;
            r_period <= i_div;
        end else if (i_en) begin
            if (o_tick) begin
                r_cnt    <= '0;
                r_period <= i_div;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_serial_tx.sv
// Wishbone classic slave that frames a payload as a mark period followed by
// FRAME_W serial bits, LSB first; TXDATA writes stall while a frame is in flight.
module wb_serial_tx
    import wb_serial_pkg::*;
#(
    parameter int               FRAME_W = FRAME_W_DEF,
    parameter logic [DIV_W-1:0] DIV_RST = 16'd1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    wb_serial_if.slave  wb,
    output logic        ena_o,
    output logic        data_o,
    output logic        busy_o
);

    localparam int BW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    tx_state_e          r_state;
    logic               r_ack;
    logic [WB_W-1:0]    r_dat;
    logic [FRAME_W-1:0] r_txdata;
    logic [FRAME_W-1:0] r_shift;
    logic [DIV_W-1:0]   r_div;
    logic [BW-1:0]      r_bit;
    logic               r_ena;
    logic               r_data;
    logic               r_busy;

    logic               w_req;
    logic [1:0]         w_sel;
    logic               w_wr;
    logic               w_wr_tx;
    logic               w_start;
    logic               w_stall;
    logic               w_ack_nxt;
    logic               w_div_wr;
    logic [DIV_W-1:0]   w_div_nxt;
    logic               w_tick;
    logic               w_last;
    logic [WB_W-1:0]    w_rdata;
    logic               w_unused;

    assign w_req     = wb.CYC_I & wb.STB_I & ~r_ack;
    assign w_sel     = wb.ADR_I[3:2];
    assign w_wr      = w_req & wb.WE_I;
    assign w_wr_tx   = w_wr & (w_sel == REG_TXDATA);
    assign w_start   = w_wr_tx & (r_state == ST_IDLE);
    assign w_stall   = w_wr_tx & (r_state != ST_IDLE);
    assign w_ack_nxt = w_req & ~w_stall;
    assign w_div_wr  = w_wr & (w_sel == REG_DIV);
    assign w_last    = (r_bit == BW'(FRAME_W - 1));

    // The timer latches the divider that will be in force after this edge.
    assign w_div_nxt = w_div_wr ? wb.DAT_I[DIV_W-1:0] : r_div;

    assign w_unused = ^{wb.ADR_I[WB_W-1:4], wb.ADR_I[1:0], wb.DAT_I[WB_W-1:DIV_W]};

    always_comb begin
        w_rdata = '0;
        unique case (w_sel)
            REG_TXDATA: w_rdata[FRAME_W-1:0] = r_txdata;
            REG_DIV:    w_rdata[DIV_W-1:0]   = r_div;
            REG_STATUS: w_rdata = status_word(r_busy, w_stall);
            default:    w_rdata = '0;
        endcase
    end

    bit_timer #(
        .W (DIV_W)
    ) u_timer (
        .i_clk     (CLK_I),
        .i_rst     (RST_I),
        .i_restart (w_start),
        .i_en      (r_busy),
        .i_div     (w_div_nxt),
        .o_tick    (w_tick)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state  <= ST_IDLE;
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_txdata <= '0;
            r_shift  <= '0;
            r_div    <= DIV_RST;
            r_bit    <= '0;
            r_ena    <= 1'b0;
            r_data   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ack <= w_ack_nxt;
            r_dat <= (w_ack_nxt & ~wb.WE_I) ? w_rdata : '0;
            if (w_div_wr) begin
                r_div <= wb.DAT_I[DIV_W-1:0];
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_txdata <= wb.DAT_I[FRAME_W-1:0];
                        r_bit    <= '0;
                        r_state  <= ST_MARK;
                        r_ena    <= 1'b1;
                        r_data   <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_MARK: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT;
                        r_bit   <= '0;
                        r_ena   <= 1'b0;
                        r_data  <= r_txdata[0];
                        r_shift <= r_txdata >> 1;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_bit   <= '0;
                            r_data  <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_data  <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wb.ACK_O = r_ack;
    assign wb.DAT_O = r_dat;
    assign ena_o    = r_ena;
    assign data_o   = r_data;
    assign busy_o   = r_busy;

endmodule

// File: doc/wb_serial_tx.md
WB_SERIAL_TX -- requirements
Module: wb_serial_tx

Interface
REQ-001 SHALL have parameter FRAME_W, default 10, serial frame width in bits.
REQ-002 SHALL have parameter DIV_RST, default 1, reset value of the DIV register.
REQ-003 SHALL have CLK_I, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have RST_I, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have CYC_I, input, 1, Wishbone cycle valid.
REQ-006 SHALL have STB_I, input, 1, Wishbone strobe.
REQ-007 SHALL have WE_I, input, 1, write enable (1 = write).
REQ-008 SHALL have ADR_I, input, 32, byte address; only ADR_I[3:2] decoded.
REQ-009 SHALL have DAT_I, input, 32, write data.
REQ-010 SHALL have DAT_O, output, 32, read data, valid while ACK_O=1.
REQ-011 SHALL have ACK_O, output, 1, Wishbone acknowledge.
REQ-012 SHALL have ena_o, output, 1, frame-start marker.
REQ-013 SHALL have data_o, output, 1, serial data, LSB first.
REQ-014 SHALL have busy_o, output, 1, serializer active.

Function
REQ-015 SHALL implement a Wishbone classic slave responder; a request is CYC_I & STB_I & !ACK_O.
REQ-016 SHALL register ACK_O: high exactly one cycle, at the earliest one cycle after a request is seen, then low for at least one cycle.
REQ-017 SHALL decode the register map: ADR_I[3:2]=0 TXDATA (RW, [FRAME_W-1:0]), =1 DIV (RW, [15:0]), =2 STATUS (RO, [0]=busy, [1]=ACK pending); =3 unmapped.
REQ-018 SHALL, for an unmapped write or a STATUS write, acknowledge normally and leave state unchanged; an unmapped read returns 0.
REQ-019 SHALL return unused upper DAT_O bits as 0 and hold DAT_O=0 whenever ACK_O=0.
REQ-020 SHALL, on a TXDATA write while idle, ack after one cycle, store DAT_I[FRAME_W-1:0] and start a frame; upper DAT_I bits are ignored.
REQ-021 SHALL, on a TXDATA write while busy, insert wait states (ACK_O low) until the FSM returns to IDLE, then ack and start the new frame in the same cycle as the ACK.
REQ-022 SHALL, if CYC_I or STB_I drops during wait states, abandon the request: no ACK, no load.
REQ-023 SHALL take a DIV write immediately; the new value applies from the next bit period, and the current bit is not truncated.
REQ-024 SHALL set bit period = DIV+1 clocks; DIV=0 gives 1 clock per bit.
REQ-025 SHALL use FSM states IDLE -> MARK -> SHIFT -> IDLE.
REQ-026 SHALL behave per state:
- MARK: ena_o=1 for one bit period, data_o=0.
- SHIFT: FRAME_W bits, each held one bit period, data_o=payload[i] for i=0 to FRAME_W-1, ena_o=0.
- After the last bit: IDLE, data_o=0.
REQ-027 SHALL drive busy_o=1 in MARK and SHIFT, and 0 in IDLE.
REQ-028 SHALL keep the internal bit counter and divider counter wrap-free: both reset to 0 at each state entry.
REQ-029 SHALL return the last written payload on a TXDATA read, including while busy; a read never stalls.

Reset
REQ-030 SHALL, on RST_I=1 at a clock edge, go to IDLE with ACK_O=0, DAT_O=0, ena_o=0, data_o=0, busy_o=0, TXDATA=0, DIV=DIV_RST.
REQ-031 SHALL, on reset mid-frame or mid-wait-state, abort with no ACK and outputs at reset values the cycle after RST_I is sampled high.
REQ-032 SHALL ignore bus requests while RST_I=1.

Structure
REQ-033 SHALL place register offsets, the FSM state enum and the default FRAME_W in package wb_serial_pkg.
REQ-034 SHALL instantiate a single sub-module, bit_timer (DIV-driven tick generator with restart input).

Verification
REQ-035 SHALL cover: DIV=1, write TXDATA=0x30201 while idle -> ACK after 1 cycle; ena_o high 2 clocks; data_o bits 1,0,0,0,0,0,0,0,0,1 at 2 clocks each; busy_o low after 22 clocks.
REQ-036 SHALL cover: second TXDATA write 0x155 issued 3 clocks into a frame -> ACK_O held low until IDLE, then ACK; next frame 1,0,1,0,1,0,1,0,1,0.
REQ-037 SHALL cover: DIV=0, write 0x3FF -> ena_o 1 clock, ten 1s at 1 clock each, busy 11 clocks.
REQ-038 SHALL cover: read STATUS mid-frame -> DAT_O=0x1; read ADR 0xC -> DAT_O=0; write ADR 0xC -> ACK with no state change.
REQ-039 SHALL cover: RST_I pulsed at bit 4 of a frame -> next cycle all outputs 0, DIV=DIV_RST; a pending stalled write receives no ACK.
REQ-040 SHALL cover: CYC_I dropped during a stalled TXDATA write -> no ACK; the frame in flight completes unchanged; no second frame.
